// File: rtl/clk_div_sequencer.sv
// Round-robin scheduler sharing one divided-tick generator among NUM_REQ requesters.
// Optional: define CLK_DIV_SEQ_TOGGLE_OUT_EN to add ClkOutput, which toggles on every tick.
module clk_div_sequencer #(
  parameter int NUM_REQ      = 4,
  parameter int FACTOR_WIDTH = 8,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            ClkEnable,
  input  logic [NUM_REQ-1:0]              Req,
  input  logic [NUM_REQ*FACTOR_WIDTH-1:0] ReqFactor,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0]  ReqCount,
  output logic [NUM_REQ-1:0]              Grant,
  output logic                            Busy,
  output logic                            TickOut,
  output logic [$clog2(NUM_REQ)-1:0]      TickOwner,
  output logic [NUM_REQ-1:0]              Done
`ifdef CLK_DIV_SEQ_TOGGLE_OUT_EN
  ,
  output logic                            ClkOutput
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RELEASE
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic                     busy_q, busy_d;
  logic                     tick_q, tick_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic [FACTOR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [FACTOR_WIDTH-1:0]  factor_q, factor_d;
  logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;

  logic                     winner_valid;
  logic [IDX_W-1:0]         winner_idx;
  logic [FACTOR_WIDTH-1:0]  owner_factor;
  logic [COUNT_WIDTH-1:0]   owner_count;
  logic                     owner_req;
  logic                     tick_due;
  logic                     last_tick;

  assign owner_factor = ReqFactor[owner_q*FACTOR_WIDTH +: FACTOR_WIDTH];
  assign owner_count  = ReqCount[owner_q*COUNT_WIDTH +: COUNT_WIDTH];
  assign owner_req    = Req[owner_q];
  assign tick_due     = ClkEnable && (cnt_q >= factor_q - FACTOR_WIDTH'(1));
  assign last_tick    = tick_due && (remaining_q == COUNT_WIDTH'(1));

  // First requesting index at or above the round-robin pointer, wrapping.
  always_comb begin
    winner_valid = 1'b0;
    winner_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!winner_valid && Req[(int'(rr_q) + i) % NUM_REQ]) begin
        winner_valid = 1'b1;
        winner_idx   = IDX_W'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state value starts from a default so no path leaves it unassigned (no latches).
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    tick_d      = 1'b0;
    done_d      = '0;
    cnt_d       = cnt_q;
    factor_d    = factor_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE: begin
        if (winner_valid) begin
          state_d             = LOAD;
          owner_d             = winner_idx;
          grant_d             = '0;
          grant_d[winner_idx] = 1'b1;
          busy_d              = 1'b1;
        end
      end

      LOAD: begin
        factor_d    = (owner_factor == '0) ? FACTOR_WIDTH'(1) : owner_factor;
        remaining_d = owner_count;
        cnt_d       = '0;
        if (owner_count == '0) begin
          // A zero-length job completes immediately, even if the request drops now.
          state_d          = RELEASE;
          grant_d          = '0;
          busy_d           = 1'b0;
          done_d[owner_q]  = 1'b1;
        end else if (!owner_req) begin
          state_d = RELEASE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (last_tick) begin
          // Final tick wins over a simultaneous abort.
          tick_d          = 1'b1;
          cnt_d           = '0;
          remaining_d     = '0;
          state_d         = RELEASE;
          grant_d         = '0;
          busy_d          = 1'b0;
          done_d[owner_q] = 1'b1;
        end else if (!owner_req) begin
          state_d = RELEASE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (tick_due) begin
          tick_d      = 1'b1;
          cnt_d       = '0;
          remaining_d = remaining_q - COUNT_WIDTH'(1);
        end else if (ClkEnable) begin
          cnt_d = cnt_q + FACTOR_WIDTH'(1);
        end
      end

      RELEASE: begin
        state_d = IDLE;
        rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= '0;
      cnt_q       <= '0;
      factor_q    <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      factor_q    <= factor_d;
      remaining_q <= remaining_d;
    end
  end

  assign Grant     = grant_q;
  assign Busy      = busy_q;
  assign TickOut   = tick_q;
  assign TickOwner = owner_q;
  assign Done      = done_q;

`ifdef CLK_DIV_SEQ_TOGGLE_OUT_EN
  logic clk_out_q, clk_out_d;

  // Toggles with each tick; cleared on an abort/empty release and during RELEASE so each owner starts low.
  always_comb begin
    clk_out_d = clk_out_q;
    if (state_q == RELEASE || (state_d == RELEASE && !tick_d)) begin
      clk_out_d = 1'b0;
    end else if (tick_d) begin
      clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
    end
  end

  assign ClkOutput = clk_out_q;
`endif

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Self-checking bench for clk_div_sequencer: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_clk_div_sequencer;

  localparam int N  = 4;
  localparam int FW = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clk_en = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*FW-1:0] req_factor = '0;
  logic [N*CW-1:0] req_count = '0;
  logic [N-1:0]    grant;
  logic            busy;
  logic            tick_out;
  logic [1:0]      tick_owner;
  logic [N-1:0]    done;
`ifdef CLK_DIV_SEQ_TOGGLE_OUT_EN
  logic            clk_output;
`endif

  clk_div_sequencer #(.NUM_REQ(N), .FACTOR_WIDTH(FW), .COUNT_WIDTH(CW)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .ClkEnable (clk_en),
    .Req       (req),
    .ReqFactor (req_factor),
    .ReqCount  (req_count),
    .Grant     (grant),
    .Busy      (busy),
    .TickOut   (tick_out),
    .TickOwner (tick_owner),
    .Done      (done)
`ifdef CLK_DIV_SEQ_TOGGLE_OUT_EN
    ,
    .ClkOutput (clk_output)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a job is an owner plus (factor, count); ticks fall on every
  // factor-th enabled cycle of the job, counted since the job started running.
  logic [N-1:0] e_grant = '0;
  logic         e_busy  = 1'b0;
  logic         e_tick  = 1'b0;
  logic [N-1:0] e_done  = '0;
  logic         e_clk   = 1'b0;
  int m_owner = 0;
  int m_rr    = 0;
  int m_age   = -1;   // -1 no job, 0 job just granted, 1 running
  bit m_rel   = 1'b0; // release cycle in progress
  int m_f = 1, m_n = 0, m_en = 0, m_ticks = 0;

  function automatic int fac_of(int i);
    return int'(req_factor[i*FW +: FW]);
  endfunction

  function automatic int cnt_of(int i);
    return int'(req_count[i*CW +: CW]);
  endfunction

  task automatic end_job(input bit completed);
    e_grant = '0;
    e_busy  = 1'b0;
    if (completed) e_done[m_owner] = 1'b1;
    else           e_clk = 1'b0;
    m_rel = 1'b1;
    m_age = -1;
  endtask

  task automatic model_step();
    bit found;
    bit due;
    e_tick = 1'b0;
    e_done = '0;
    if (reset) begin
      e_grant = '0; e_busy = 1'b0; e_clk = 1'b0;
      m_owner = 0; m_rr = 0; m_age = -1; m_rel = 1'b0;
      return;
    end
    if (m_rel) begin
      m_rel = 1'b0;
      m_rr  = (m_owner + 1) % N;
      e_clk = 1'b0;
    end else if (m_age < 0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(m_rr + i) % N]) begin
          found   = 1'b1;
          m_owner = (m_rr + i) % N;
        end
      end
      if (found) begin
        e_grant = '0;
        e_grant[m_owner] = 1'b1;
        e_busy = 1'b1;
        m_age  = 0;
      end
    end else if (m_age == 0) begin
      m_f = (fac_of(m_owner) == 0) ? 1 : fac_of(m_owner);
      m_n = cnt_of(m_owner);
      if (m_n == 0)               end_job(1'b1);
      else if (!req[m_owner])     end_job(1'b0);
      else begin
        m_age = 1; m_en = 0; m_ticks = 0;
      end
    end else begin
      due = 1'b0;
      if (clk_en) begin
        m_en++;
        due = (m_en % m_f) == 0;
      end
      if (due && (m_ticks + 1 == m_n)) begin
        e_tick = 1'b1;
        e_clk  = ~e_clk;
        end_job(1'b1);
      end else if (!req[m_owner]) begin
        end_job(1'b0);
      end else if (due) begin
        m_ticks++;
        e_tick = 1'b1;
        e_clk  = ~e_clk;
      end
    end
  endtask

  // Observation for the directed scenarios.
  int cyc = 0;
  int ticks_seen = 0;
  int done_cnt[N];
  int tick_cycs[$];
  int owners[$];
  int grant_cycs[$];
  logic [N-1:0] prev_grant = '0;

  task automatic start_phase();
    ticks_seen = 0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    tick_cycs.delete();
    owners.delete();
    grant_cycs.delete();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    check("grant", grant, e_grant);
    check("busy", busy, e_busy);
    check("tick", tick_out, e_tick);
    check("done", done, e_done);
    check("owner", tick_owner, m_owner);
`ifdef CLK_DIV_SEQ_TOGGLE_OUT_EN
    check("clkout", clk_output, e_clk);
`endif
    if (tick_out) begin
      ticks_seen++;
      tick_cycs.push_back(cyc);
    end
    for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
    if (grant != '0 && prev_grant == '0) begin
      owners.push_back(int'(tick_owner));
      grant_cycs.push_back(cyc);
    end
    prev_grant = grant;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic check_spacing(input string tag, input int gap);
    for (int i = 1; i < tick_cycs.size(); i++) check(tag, tick_cycs[i] - tick_cycs[i-1], gap);
  endtask

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    do_reset();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", tick_out, 0);
    check("rst_done", done, 0);
    check("rst_owner", tick_owner, 0);

    // Single grant: factor 3, count 4.
    clk_en = 1'b1;
    req_factor[0 +: FW] = 8'd3;
    req_count[0 +: CW]  = 8'd4;
    start_phase();
    req = 4'b0001;
    cycle();
    check("single_grant_t1", grant, 4'b0001);
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (done[0]) req[0] = 1'b0;
    end
    check("single_ticks", ticks_seen, 4);
    check("single_done", done_cnt[0], 1);
    check_spacing("single_spacing", 3);

    // Round robin: all requesters, factor 1, count 2.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_factor[i*FW +: FW] = 8'd1;
      req_count[i*CW +: CW]  = 8'd2;
    end
    start_phase();
    req = 4'b1111;
    for (int k = 0; k < 30; k++) cycle();
    check("rr_grants", owners.size() >= 5, 1);
    for (int i = 0; i < 5 && i < owners.size(); i++) check("rr_order", owners[i], exp_rr[i]);

    // Factor 0 acts as 1: one tick, one cycle into RUN.
    do_reset();
    req_factor[0 +: FW] = 8'd0;
    req_count[0 +: CW]  = 8'd1;
    start_phase();
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (done[0]) req[0] = 1'b0;
    end
    check("f0_ticks", ticks_seen, 1);
    check("f0_done", done_cnt[0], 1);
    if (tick_cycs.size() > 0 && grant_cycs.size() > 0)
      check("f0_latency", tick_cycs[0] - grant_cycs[0], 2);

    // Count 0: Done without ticks.
    do_reset();
    req_count[0 +: CW] = 8'd0;
    start_phase();
    req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (done[0]) req[0] = 1'b0;
    end
    check("c0_ticks", ticks_seen, 0);
    check("c0_done", done_cnt[0], 1);

    // ClkEnable every 4th cycle, factor 2, count 3.
    do_reset();
    req_factor[0 +: FW] = 8'd2;
    req_count[0 +: CW]  = 8'd3;
    start_phase();
    req = 4'b0001;
    for (int k = 0; k < 60; k++) begin
      clk_en = (cyc % 4) == 0;
      cycle();
      if (done[0]) req[0] = 1'b0;
    end
    check("gate_ticks", ticks_seen, 3);
    check_spacing("gate_spacing", 8);
    clk_en = 1'b1;

    // Abort requester 0 after 2 of 5 ticks; requester 1 follows.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      req_factor[i*FW +: FW] = 8'd1;
      req_count[i*CW +: CW]  = 8'd5;
    end
    start_phase();
    req = 4'b0011;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (req[0] && ticks_seen == 2) req[0] = 1'b0;
      if (done[1]) req[1] = 1'b0;
    end
    check("abort_done0", done_cnt[0], 0);
    check("abort_done1", done_cnt[1], 1);
    check("abort_ticks", ticks_seen, 7);
    check("abort_grants", owners.size(), 2);
    if (owners.size() >= 2) check("abort_next", owners[1], 1);

    // Reset in the middle of a run.
    do_reset();
    req_factor[0 +: FW] = 8'd3;
    req_count[0 +: CW]  = 8'd10;
    req = 4'b0001;
    for (int k = 0; k < 8; k++) cycle();
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    cycle();
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tick", tick_out, 0);
    check("mid_rst_done", done, 0);
    reset = 1'b0;
    req = '0;

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      reset  = ($urandom_range(0, 599) == 0);
      clk_en = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!req[i])                               req[i] = ($urandom_range(0, 3) == 0);
        else if (done[i])                          req[i] = ($urandom_range(0, 1) == 0);
        else if ($urandom_range(0, 39) == 0)       req[i] = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        int j;
        j = $urandom_range(0, N - 1);
        req_factor[j*FW +: FW] = 8'($urandom_range(0, 5));
        req_count[j*CW +: CW]  = 8'($urandom_range(0, 6));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_sequencer.md
Name: clk_div_sequencer

Overview:
Round-robin scheduler that shares one adjustable divided-tick generator among NUM_REQ requesters. Each requester supplies a divide factor and a tick count. The block grants the divider to one requester at a time, runs exactly that many divided ticks, then releases it. It sits between slow-rate consumers (PWM, tone and strobe engines) and the base clock-enable chain.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
FACTOR_WIDTH, 8, width of each divide factor
COUNT_WIDTH, 8, width of each tick count

Ports:
Clk  input  1  system clock; all logic on posedge
Reset  input  1  synchronous, active-high reset
ClkEnable  input  1  base enable; the divider counter advances only on cycles where it is high
Req  input  NUM_REQ  per-requester request level; held high until Done or voluntary abort
ReqFactor  input  NUM_REQ*FACTOR_WIDTH  packed divide factors; requester i uses slice [i*FACTOR_WIDTH +: FACTOR_WIDTH]
ReqCount  input  NUM_REQ*COUNT_WIDTH  packed tick counts; same slicing rule
Grant  output  NUM_REQ  one-hot owner; all zero when no owner
Busy  output  1  high in LOAD and RUN
TickOut  output  1  one-cycle pulse per divided tick for the current owner
TickOwner  output  clog2(NUM_REQ)  index of the current or last owner
Done  output  NUM_REQ  one-cycle pulse to the owner on completion

Behaviour:
- Reset: state IDLE; Grant=0, Busy=0, TickOut=0, Done=0, TickOwner=0, rr pointer=0, divider counter=0, remaining=0.
- FSM states: IDLE, LOAD, RUN, RELEASE.
- IDLE
  - If any Req bit is high, select the first set bit searching from the rr pointer upward, with wrap.
  - Go to LOAD and set Grant and TickOwner for the winner.
  - If no Req bit is high, stay in IDLE.
- LOAD (exactly 1 cycle)
  - Latch the winner's factor and count.
  - A factor of 0 is treated as 1.
  - Clear the divider counter and go to RUN.
  - If the latched count is 0, go directly to RELEASE and fire Done; no ticks are produced.
- RUN
  - On each ClkEnable cycle: if counter >= factor-1, set counter=0, pulse TickOut next edge, and decrement remaining. Otherwise increment the counter.
  - With ClkEnable low, the counter holds.
  - When the tick that brings remaining to 0 is issued, go to RELEASE.
- RELEASE (exactly 1 cycle)
  - Grant=0, Busy=0.
  - Done[owner] pulses only if the run completed normally.
  - Set rr pointer = owner+1, with wrap.
  - Next state is IDLE.
- Abort: if Req[owner] drops during LOAD or RUN, go to RELEASE on the next edge. No further TickOut and no Done.
- Latency
  - Req rises at edge t (block in IDLE) -> Grant at t+1 -> RUN at t+2.
  - The first TickOut occurs after `factor` ClkEnable cycles in RUN.
  - There is at least one cycle with Grant=0 between consecutive owners.
- Inputs during a run: changes to ReqFactor or ReqCount after LOAD are ignored.
- Simultaneous events: the final tick and an abort in the same cycle count as completion, so Done fires.
- Widths: the counter is FACTOR_WIDTH bits and remaining is COUNT_WIDTH bits. Neither wraps, because the compare-then-reset and the stop-at-0 rules prevent it.
- Reset mid-operation: returns immediately to the reset values. No Done is issued.

Optional Feature:
- Macro: CLK_DIV_SEQ_TOGGLE_OUT_EN.
- When defined:
  - Adds output port ClkOutput (1 bit), reset 0.
  - ClkOutput toggles on every TickOut pulse.
  - It is forced to 0 on entry to RELEASE, so every owner starts from low.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Single grant: Reset, ClkEnable=1, Req=0001, factor0=3, count0=4 -> Grant=0001 at t+1; 4 TickOut pulses spaced 3 cycles apart; Done[0] one pulse; Grant=0 in RELEASE.
- Round robin: Req=1111 held, every factor=1, every count=2 -> owners in order 0,1,2,3,0. Each owner gets 2 consecutive-cycle ticks, then one idle-Grant gap.
- Edge values: factor=0, count=1 -> exactly 1 tick, 1 cycle into RUN. Separately, count=0 -> LOAD, then RELEASE with Done; no TickOut.
- ClkEnable gating: factor=2, count=3, ClkEnable asserted every 4th cycle -> ticks spaced 8 Clk cycles apart; the counter holds while ClkEnable=0.
- Abort and reset
  - Abort: Req0 dropped after 2 of 5 ticks -> RELEASE next edge, no Done[0], and requester 1 is granted next.
  - Reset: Reset asserted mid-RUN -> all outputs return to reset values at the next edge.
- Toggle (with CLK_DIV_SEQ_TOGGLE_OUT_EN): count=3 -> ClkOutput goes 0,1,0,1, then returns to 0 in RELEASE.
